branch_target_buffer: RTL

- Direct-mapped branch target buffer (BTB) with per-entry saturating direction counters.
- Sits beside the program counter in IF. Predicts the next PC for branches and jumps, so the pipeline no longer has to wait for EX resolution and flush on every taken branch.
- Trained from EX, where branch outcome and target are resolved.
- Parametrised in entry count, address width and counter width; keeps a saturating misprediction counter for performance analysis.

---
 rtl/branch_target_buffer.sv | 133 +++++++++++++
 1 files changed

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters.
// Lookup is combinational from IF; training comes from EX one update per cycle.

module btb_entry #(
    parameter int TAG_W  = 26,
    parameter int ADDR_W = 32,
    parameter int CTR_W  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inval,
    input  logic              we,
    input  logic              upd_taken,
    input  logic              upd_uncond,
    input  logic [TAG_W-1:0]  upd_tag,
    input  logic [ADDR_W-1:0] upd_target,
    output logic              valid,
    output logic [TAG_W-1:0]  tag,
    output logic [ADDR_W-1:0] target,
    output logic [CTR_W-1:0]  ctr
);
    localparam logic [CTR_W-1:0] CTR_MAX = '1;
    localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1) << (CTR_W - 1);
    localparam logic [CTR_W-1:0] CTR_WNT = CTR_WT - CTR_W'(1);

    logic hit;
    assign hit = valid && (tag == upd_tag);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            ctr   <= CTR_WNT;
        end else if (inval) begin
            valid <= 1'b0;
        end else if (we) begin
            if (hit) begin
                if (upd_uncond)
                    ctr <= CTR_MAX;
                else if (upd_taken && ctr != CTR_MAX)
                    ctr <= ctr + CTR_W'(1);
                else if (!upd_taken && ctr != '0)
                    ctr <= ctr - CTR_W'(1);
            end else if (upd_taken) begin
                valid <= 1'b1;
                ctr   <= upd_uncond ? CTR_MAX : CTR_WT;
            end
        end
    end

    // Tag/target carry no reset: they are only observed while valid is set.
    always_ff @(posedge clk) begin
        if (!inval && we && (upd_taken || (hit && upd_uncond))) begin
            tag    <= upd_tag;
            target <= upd_target;
        end
    end
endmodule

module branch_target_buffer #(
    parameter int ENTRIES = 16,
    parameter int ADDR_W  = 32,
    parameter int CTR_W   = 2,
    parameter int PERF_W  = 16
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic [ADDR_W-1:0] lu_pc,
    output logic              lu_hit,
    output logic              lu_taken,
    output logic [ADDR_W-1:0] lu_target,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic              upd_uncond,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_pred_taken,
    input  logic [ADDR_W-1:0] upd_pred_target,
    input  logic              inval_all,
    output logic              mispredict,
    output logic [PERF_W-1:0] mispred_cnt
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    logic [IDX_W-1:0] lu_idx, upd_idx;
    logic [TAG_W-1:0] lu_tag, upd_tag;

    logic [ENTRIES-1:0]             ent_valid;
    logic [ENTRIES-1:0][TAG_W-1:0]  ent_tag;
    logic [ENTRIES-1:0][ADDR_W-1:0] ent_target;
    logic [ENTRIES-1:0][CTR_W-1:0]  ent_ctr;

    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^upd_pc[1:0];

    assign lu_idx  = lu_pc[IDX_W+1:2];
    assign lu_tag  = lu_pc[ADDR_W-1:IDX_W+2];
    assign upd_idx = upd_pc[IDX_W+1:2];
    assign upd_tag = upd_pc[ADDR_W-1:IDX_W+2];

    for (genvar i = 0; i < ENTRIES; i++) begin : g_ent
        btb_entry #(.TAG_W(TAG_W), .ADDR_W(ADDR_W), .CTR_W(CTR_W)) u_ent (
            .clk        (CLK),
            .rst_n      (nRST),
            .inval      (inval_all),
            .we         (upd_valid && (upd_idx == IDX_W'(i))),
            .upd_taken  (upd_taken),
            .upd_uncond (upd_uncond),
            .upd_tag    (upd_tag),
            .upd_target (upd_target),
            .valid      (ent_valid[i]),
            .tag        (ent_tag[i]),
            .target     (ent_target[i]),
            .ctr        (ent_ctr[i])
        );
    end

    // No bypass: a same-cycle update shows up in lookups from the next cycle.
    assign lu_hit    = ent_valid[lu_idx] && (ent_tag[lu_idx] == lu_tag);
    assign lu_taken  = lu_hit && ent_ctr[lu_idx][CTR_W-1];
    assign lu_target = lu_taken ? ent_target[lu_idx] : lu_pc + ADDR_W'(4);

    assign mispredict = nRST && upd_valid &&
                        ((upd_pred_taken != upd_taken) ||
                         (upd_taken && (upd_pred_target != upd_target)));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            mispred_cnt <= '0;
        else if (mispredict && mispred_cnt != '1)
            mispred_cnt <= mispred_cnt + PERF_W'(1);
    end
endmodule
